pc_unit: RTL and testbench

Parametrised program-counter unit for the pipelined core. It holds the fetch PC and selects the next PC from:
- sequential increment
- EX-stage branch redirect
- ID-stage jump, call or return
- exception vector
It contains a circular return-address stack (RAS), so returns are predicted in ID without waiting for the register file. It replaces the plain PC register at the front of the IF stage.

---
 rtl/pc_unit_if.sv | 33 +++
 rtl/pc_unit.sv | 96 +++++++++
 tb/tb_pc_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Request/status bundle between the IF-stage control logic and the program-counter unit.
// Requests flow master -> slave; the PC and RAS status flow back.
interface pc_unit_if #(
    parameter int unsigned PC_SIZE = 18,
    parameter int unsigned RAS_AW  = 2
);
    logic               pc_write;
    logic               exc_valid;
    logic               br_taken;
    logic [PC_SIZE-1:0] br_target;
    logic               jmp_valid;
    logic [PC_SIZE-1:0] jmp_target;
    logic               call_valid;
    logic [PC_SIZE-1:0] call_ret_addr;
    logic               ret_valid;
    logic [PC_SIZE-1:0] pc_out;
    logic [PC_SIZE-1:0] pc_next;
    logic               redirect;
    logic [RAS_AW:0]    ras_count;
    logic               ras_underflow;

    modport master (
        output pc_write, exc_valid, br_taken, br_target, jmp_valid, jmp_target,
               call_valid, call_ret_addr, ret_valid,
        input  pc_out, pc_next, redirect, ras_count, ras_underflow
    );

    modport slave (
        input  pc_write, exc_valid, br_taken, br_target, jmp_valid, jmp_target,
               call_valid, call_ret_addr, ret_valid,
        output pc_out, pc_next, redirect, ras_count, ras_underflow
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised next-PC selection and a circular return-address stack.
// All state advances on the falling clock edge, in step with the rest of the pipeline.
module pc_unit #(
    parameter int unsigned               PC_SIZE   = 18,
    parameter int unsigned               PC_STEP   = 4,
    parameter logic [PC_SIZE-1:0]        RESET_VEC = '0,
    parameter logic [PC_SIZE-1:0]        EXC_VEC   = PC_SIZE'(18'h00100),
    parameter int unsigned               RAS_DEPTH = 4,
    parameter int unsigned               RAS_AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    pc_unit_if.slave    bus
);
    localparam int unsigned CW = RAS_AW + 1;

    logic [PC_SIZE-1:0] pc_q, pc_d;
    logic               redirect_q, redirect_d;
    logic [RAS_AW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               under_q, under_d;
    logic [PC_SIZE-1:0] mem_q [RAS_DEPTH];
    logic [PC_SIZE-1:0] mem_d [RAS_DEPTH];

    logic [PC_SIZE-1:0] pc_inc;
    logic [RAS_AW-1:0]  ptr_dec;

    assign pc_inc  = pc_q + PC_SIZE'(PC_STEP);
    assign ptr_dec = ptr_q - RAS_AW'(1);

    // Next-PC priority and RAS bookkeeping; calls/returns only act when nothing older redirects.
    always_comb begin
        pc_d       = pc_inc;
        redirect_d = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        under_d    = 1'b0;
        mem_d      = mem_q;
        if (bus.exc_valid) begin
            pc_d       = EXC_VEC;
            redirect_d = 1'b1;
            ptr_d      = '0;
            cnt_d      = '0;
        end else if (bus.br_taken) begin
            pc_d       = bus.br_target;
            redirect_d = 1'b1;
        end else if (!bus.pc_write) begin
            pc_d = pc_q;
        end else if (bus.call_valid) begin
            pc_d         = bus.jmp_target;
            redirect_d   = 1'b1;
            mem_d[ptr_q] = bus.call_ret_addr;
            ptr_d        = ptr_q + RAS_AW'(1);
            if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (bus.ret_valid) begin
            redirect_d = 1'b1;
            if (cnt_q != '0) begin
                pc_d  = mem_q[ptr_dec];
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
            end else begin
                under_d = 1'b1;
            end
        end else if (bus.jmp_valid) begin
            pc_d       = bus.jmp_target;
            redirect_d = 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            under_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            under_q    <= under_d;
        end
    end

    // Stack entries carry no reset; only the pointer and count define validity.
    always_ff @(negedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.pc_out        = pc_q;
    assign bus.pc_next       = pc_d;
    assign bus.redirect      = redirect_q;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_underflow = under_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed-vector bench for pc_unit with hand-computed expectations.
module tb_pc_unit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pc_unit_if #(.PC_SIZE(18), .RAS_AW(2)) bus ();

    pc_unit #(
        .PC_SIZE(18), .PC_STEP(4), .RESET_VEC(18'h0), .EXC_VEC(18'h00100),
        .RAS_DEPTH(4), .RAS_AW(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one active (falling) edge and settle before checking or driving.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.exc_valid  = 1'b0;
        bus.br_taken   = 1'b0;
        bus.jmp_valid  = 1'b0;
        bus.call_valid = 1'b0;
        bus.ret_valid  = 1'b0;
        bus.pc_write   = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [17:0] pc, input logic rd,
                             input logic [2:0] cnt, input logic uf);
        chk({tag, ".pc"},  32'(bus.pc_out),        32'(pc));
        chk({tag, ".rd"},  32'(bus.redirect),      32'(rd));
        chk({tag, ".cnt"}, 32'(bus.ras_count),     32'(cnt));
        chk({tag, ".uf"},  32'(bus.ras_underflow), 32'(uf));
    endtask

    initial begin
        logic [17:0] rets [5];
        logic [2:0]  cnt_exp;
        n_vec = 0;
        n_err = 0;
        rets[0] = 18'h10; rets[1] = 18'h20; rets[2] = 18'h30; rets[3] = 18'h40; rets[4] = 18'h50;
        idle();
        bus.br_target = '0; bus.jmp_target = '0; bus.call_ret_addr = '0;
        rst = 1'b1;
        #1;
        step();
        chk_state("reset", 18'h0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // Sequential fetch then reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_state($sformatf("seq%0d", i), 18'(4 * i), 1'b0, 3'd0, 1'b0);
        end
        rst = 1'b1;
        step();
        chk_state("rst12", 18'h0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;

        // Stall blocks a jump; a branch overrides the stall
        bus.pc_write = 1'b0; bus.jmp_valid = 1'b1; bus.jmp_target = 18'h40;
        #1 chk("stall.next", 32'(bus.pc_next), 32'h0);
        step(); chk_state("stall1", 18'h0, 1'b0, 3'd0, 1'b0);
        step(); chk_state("stall2", 18'h0, 1'b0, 3'd0, 1'b0);
        bus.br_taken = 1'b1; bus.br_target = 18'h200;
        #1 chk("br.next", 32'(bus.pc_next), 32'h200);
        step(); chk_state("br", 18'h200, 1'b1, 3'd0, 1'b0);
        idle();

        // Five calls into a four-deep stack, then five returns
        bus.call_valid = 1'b1; bus.jmp_target = 18'h100;
        for (int i = 0; i < 5; i++) begin
            bus.call_ret_addr = rets[i];
            step();
            cnt_exp = (i < 3) ? 3'(i + 1) : 3'd4;
            chk_state($sformatf("call%0d", i), 18'h100, 1'b1, cnt_exp, 1'b0);
        end
        idle();
        bus.ret_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_state($sformatf("ret%0d", i), rets[4 - i], 1'b1, 3'(3 - i), 1'b0);
        end
        step(); chk_state("ret_uf", 18'h24, 1'b1, 3'd0, 1'b1);
        idle();
        step(); chk_state("post_uf", 18'h28, 1'b0, 3'd0, 1'b0);

        // Call beats a simultaneous return; exception clears the stack
        bus.call_valid = 1'b1; bus.jmp_target = 18'h100;
        bus.call_ret_addr = 18'hA0; step();
        bus.call_ret_addr = 18'hB0; step();
        chk_state("pre_cr", 18'h100, 1'b1, 3'd2, 1'b0);
        bus.ret_valid = 1'b1; bus.jmp_target = 18'h300; bus.call_ret_addr = 18'hC0;
        step(); chk_state("call_ret", 18'h300, 1'b1, 3'd3, 1'b0);
        bus.call_valid = 1'b0;
        step(); chk_state("pop_c0", 18'hC0, 1'b1, 3'd2, 1'b0);
        bus.call_valid = 1'b1; bus.exc_valid = 1'b1;
        step(); chk_state("exc", 18'h100, 1'b1, 3'd0, 1'b0);
        idle(); bus.ret_valid = 1'b1;
        step(); chk_state("exc_ret", 18'h104, 1'b1, 3'd0, 1'b1);
        idle();

        // PC wraps modulo 2^18
        bus.jmp_valid = 1'b1; bus.jmp_target = 18'h3FFFC;
        step(); chk_state("jmp_top", 18'h3FFFC, 1'b1, 3'd0, 1'b0);
        idle();
        step(); chk_state("wrap", 18'h0, 1'b0, 3'd0, 1'b0);

        // Stalled call is neither taken nor pushed
        bus.pc_write = 1'b0; bus.call_valid = 1'b1; bus.jmp_target = 18'h500;
        bus.call_ret_addr = 18'h77;
        step(); chk_state("stall_call", 18'h0, 1'b0, 3'd0, 1'b0);
        bus.pc_write = 1'b1;
        step(); chk_state("call_go", 18'h500, 1'b1, 3'd1, 1'b0);

        // Branch suppresses a return
        bus.call_valid = 1'b0; bus.ret_valid = 1'b1;
        bus.br_taken = 1'b1; bus.br_target = 18'h900;
        step(); chk_state("br_ret", 18'h900, 1'b1, 3'd1, 1'b0);
        bus.br_taken = 1'b0;
        step(); chk_state("ret_77", 18'h77, 1'b1, 3'd0, 1'b0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
